// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port 1024 x 64-bit data RAM between the read-only fetch port
// and the read/write data port through an IDLE/ACCESS/WAIT/RESP sequencer.
module mem_port_arbiter #(
    parameter int MEM_DEPTH  = 1024,
    parameter int MEM_AW     = 10,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [63:0]       f_addr,
    output logic [63:0]       f_rdata,
    output logic              f_done,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [63:0]       d_addr,
    input  logic [63:0]       d_wdata,
    output logic [63:0]       d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [63:0]     DEPTH_W    = 64'(MEM_DEPTH);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [2:0]      WAIT_LAST  = 3'(READ_LAT - 1);

    logic [1:0]        state_q,     state_d;
    logic [SW-1:0]     starve_q,    starve_d;
    logic              owner_q,     owner_d;
    logic              we_q,        we_d;
    logic [2:0]        wait_q,      wait_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q,  mem_addr_d;
    logic [63:0]       mem_wdata_q, mem_wdata_d;
    logic              f_done_q,    f_done_d;
    logic              d_done_q,    d_done_d;
    logic              f_err_q,     f_err_d;
    logic              d_err_q,     d_err_d;
    logic [63:0]       f_rdata_q,   f_rdata_d;
    logic [63:0]       d_rdata_q,   d_rdata_d;

    logic              grant_d_s;
    logic              grant_f_s;
    logic [63:0]       sel_addr_s;
    logic              sel_we_s;
    logic [63:0]       sel_wdata_s;
    logic              in_range_s;

    // Grant decision: data wins unless fetch has waited STARVE_MAX data grants.
    always_comb begin
        grant_d_s   = 1'b0;
        grant_f_s   = 1'b0;
        sel_addr_s  = 64'd0;
        sel_we_s    = 1'b0;
        sel_wdata_s = 64'd0;
        if (d_req && !(f_req && (starve_q == STARVE_LIM))) begin
            grant_d_s   = 1'b1;
            sel_addr_s  = d_addr;
            sel_we_s    = d_we;
            sel_wdata_s = d_wdata;
        end else if (f_req) begin
            grant_f_s   = 1'b1;
            sel_addr_s  = f_addr;
        end else begin
            grant_d_s   = 1'b0;
            grant_f_s   = 1'b0;
        end
        in_range_s = (sel_addr_s < DEPTH_W);
    end

    // Sequencer next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        we_d        = we_q;
        wait_d      = wait_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        f_done_d    = 1'b0;
        d_done_d    = 1'b0;
        f_err_d     = 1'b0;
        d_err_d     = 1'b0;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d_s || grant_f_s) begin
                    owner_d = grant_d_s;
                    we_d    = sel_we_s;
                    if (in_range_s) begin
                        state_d     = ST_ACCESS;
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_we_s;
                        mem_addr_d  = sel_addr_s[MEM_AW-1:0];
                        mem_wdata_d = sel_wdata_s;
                    end else begin
                        // Out-of-range: answer next cycle, RAM is never touched.
                        state_d  = ST_RESP;
                        d_done_d = grant_d_s;
                        d_err_d  = grant_d_s;
                        f_done_d = grant_f_s;
                        f_err_d  = grant_f_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
                if (grant_f_s) begin
                    starve_d = '0;
                end else if (grant_d_s && f_req) begin
                    starve_d = starve_q + SW'(1);
                end else begin
                    starve_d = starve_q;
                end
            end
            ST_ACCESS: begin
                state_d = ST_WAIT;
                wait_d  = 3'd0;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d  = ST_RESP;
                    d_done_d = owner_q;
                    f_done_d = !owner_q;
                    if (!we_q && owner_q) begin
                        d_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        f_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            wait_q      <= 3'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 64'd0;
            f_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            f_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
            f_rdata_q   <= 64'd0;
            d_rdata_q   <= 64'd0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            wait_q      <= wait_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            f_done_q    <= f_done_d;
            d_done_q    <= d_done_d;
            f_err_q     <= f_err_d;
            d_err_q     <= d_err_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign f_done    = f_done_q;
    assign d_done    = d_done_q;
    assign f_err     = f_err_q;
    assign d_err     = d_err_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;

    mem_port_arbiter_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .mem_en (mem_en_q),
        .mem_we (mem_we_q),
        .f_done (f_done_q),
        .d_done (d_done_q),
        .f_err  (f_err_q),
        .d_err  (d_err_q)
    );

endmodule

// Protocol properties of the arbiter outputs.
module mem_port_arbiter_chk (
    input logic clk,
    input logic rst_n,
    input logic mem_en,
    input logic mem_we,
    input logic f_done,
    input logic d_done,
    input logic f_err,
    input logic d_err
);

    a_we_needs_en: assert property (@(posedge clk) disable iff (!rst_n) mem_we |-> mem_en);
    a_one_done:    assert property (@(posedge clk) disable iff (!rst_n) !(f_done && d_done));
    a_f_err_done:  assert property (@(posedge clk) disable iff (!rst_n) f_err |-> f_done);
    a_d_err_done:  assert property (@(posedge clk) disable iff (!rst_n) d_err |-> d_done);
    a_no_en_done:  assert property (@(posedge clk) disable iff (!rst_n) mem_en |-> !(f_done || d_done));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: default build (READ_LAT=1) on a modelled RAM,
// plus a READ_LAT=3 build for the latency case.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_clr = 1'b1;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;

    // Instance A (READ_LAT=1)
    logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [63:0] f_addr = 64'd0, d_addr = 64'd0, d_wdata = 64'd0;
    logic [63:0] f_rdata_a, d_rdata_a, mem_wdata_a, mem_rdata_a;
    logic        f_done_a, f_err_a, d_done_a, d_err_a, mem_en_a, mem_we_a;
    logic [9:0]  mem_addr_a;

    // Instance B (READ_LAT=3)
    logic        f_req_b = 1'b0, d_req_b = 1'b0, d_we_b = 1'b0;
    logic [63:0] f_addr_b = 64'd0, d_addr_b = 64'd0, d_wdata_b = 64'd0;
    logic [63:0] f_rdata_b, d_rdata_b, mem_wdata_b, mem_rdata_b;
    logic        f_done_b, f_err_b, d_done_b, d_err_b, mem_en_b, mem_we_b;
    logic [9:0]  mem_addr_b;

    logic [63:0] ram_a [1024];
    logic        ram_a_vld [1024];
    logic [63:0] ra_pipe = 64'd0;
    logic [63:0] rb_pipe [3];
    int          en_cnt_a = 0, we_cnt_a = 0, done_cnt_a = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_DEPTH(1024), .MEM_AW(10), .READ_LAT(1), .STARVE_MAX(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata_a), .f_done(f_done_a), .f_err(f_err_a),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata_a), .d_done(d_done_a), .d_err(d_err_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    mem_port_arbiter #(.MEM_DEPTH(1024), .MEM_AW(10), .READ_LAT(3), .STARVE_MAX(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req_b), .f_addr(f_addr_b), .f_rdata(f_rdata_b), .f_done(f_done_b), .f_err(f_err_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .d_rdata(d_rdata_b), .d_done(d_done_b), .d_err(d_err_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    // Unwritten words read back as 0x1000 + address.
    function automatic logic [63:0] ram_a_rd(input logic [9:0] a);
        return ram_a_vld[a] ? ram_a[a] : (64'h1000 + 64'(a));
    endfunction

    // RAM model A: 1-cycle read latency, read data is 0 when no read was strobed.
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) ram_a_vld[i] <= 1'b0;
        end else if (mem_en_a && mem_we_a) begin
            ram_a[mem_addr_a]     <= mem_wdata_a;
            ram_a_vld[mem_addr_a] <= 1'b1;
        end
        ra_pipe <= (mem_en_a && !mem_we_a) ? ram_a_rd(mem_addr_a) : 64'd0;
        if (mem_en_a) en_cnt_a <= en_cnt_a + 1;
        if (mem_we_a) we_cnt_a <= we_cnt_a + 1;
        if (f_done_a || d_done_a) done_cnt_a <= done_cnt_a + 1;
    end
    assign mem_rdata_a = ra_pipe;

    // RAM model B: read-only, 3-cycle pipeline.
    always @(posedge clk) begin
        rb_pipe[0] <= mem_en_b ? (64'h1000 + 64'(mem_addr_b)) : 64'd0;
        rb_pipe[1] <= rb_pipe[0];
        rb_pipe[2] <= rb_pipe[1];
    end
    assign mem_rdata_b = rb_pipe[2];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++; if ({mem_en_a, mem_we_a, f_done_a, d_done_a, f_err_a, d_err_a} !== 6'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b, expected 000000", {mem_en_a, mem_we_a, f_done_a, d_done_a, f_err_a, d_err_a}); end
        n_checks++; if (mem_addr_a !== 10'd0 || mem_wdata_a !== 64'd0) begin
            n_fail++; $display("FAIL reset_mem: got addr %0d wdata %h, expected 0 0", mem_addr_a, mem_wdata_a); end
        n_checks++; if (f_rdata_a !== 64'd0 || d_rdata_a !== 64'd0) begin
            n_fail++; $display("FAIL reset_rdata: got %h %h, expected 0 0", f_rdata_a, d_rdata_a); end
        ram_clr = 1'b0;
        rst_n   = 1'b1;
        tick();
    endtask

    task automatic test_read_after_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'd5; d_wdata = 64'hDEAD_BEEF;
        tick();
        n_checks++; if (mem_en_a !== 1'b1 || mem_we_a !== 1'b1 || mem_addr_a !== 10'd5 || mem_wdata_a !== 64'hDEAD_BEEF) begin
            n_fail++; $display("FAIL raw_wr_access: got en %b we %b addr %0d wdata %h, expected 1 1 5 deadbeef",
                               mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a); end
        d_we = 1'b0; d_addr = 64'd9; d_wdata = 64'h0BAD;
        tick();
        n_checks++; if (mem_en_a !== 1'b0 || d_done_a !== 1'b0) begin
            n_fail++; $display("FAIL raw_wr_wait: got en %b done %b, expected 0 0", mem_en_a, d_done_a); end
        tick();
        n_checks++; if (d_done_a !== 1'b1 || d_err_a !== 1'b0 || f_done_a !== 1'b0) begin
            n_fail++; $display("FAIL raw_wr_done: got d_done %b d_err %b f_done %b, expected 1 0 0", d_done_a, d_err_a, f_done_a); end
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'd5;
        tick();
        n_checks++; if (mem_en_a !== 1'b1 || mem_we_a !== 1'b0 || mem_addr_a !== 10'd5) begin
            n_fail++; $display("FAIL raw_rd_access: got en %b we %b addr %0d, expected 1 0 5", mem_en_a, mem_we_a, mem_addr_a); end
        tick();
        tick();
        n_checks++; if (d_done_a !== 1'b1 || d_err_a !== 1'b0 || d_rdata_a !== 64'hDEAD_BEEF) begin
            n_fail++; $display("FAIL raw_rd_done: got done %b err %b rdata %h, expected 1 0 deadbeef", d_done_a, d_err_a, d_rdata_a); end
        d_req = 1'b0;
        tick();
        n_checks++; if (d_done_a !== 1'b0 || d_rdata_a !== 64'hDEAD_BEEF) begin
            n_fail++; $display("FAIL raw_rdata_hold: got done %b rdata %h, expected 0 deadbeef", d_done_a, d_rdata_a); end
    endtask

    task automatic test_out_of_range();
        int en0;
        en0 = en_cnt_a;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'd1024; d_wdata = 64'h5555;
        tick();
        n_checks++; if (d_done_a !== 1'b1 || d_err_a !== 1'b1 || mem_en_a !== 1'b0) begin
            n_fail++; $display("FAIL oor_data: got done %b err %b en %b, expected 1 1 0", d_done_a, d_err_a, mem_en_a); end
        d_req = 1'b0;
        tick();
        f_req = 1'b1; f_addr = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        n_checks++; if (f_done_a !== 1'b1 || f_err_a !== 1'b1 || d_done_a !== 1'b0 || mem_en_a !== 1'b0) begin
            n_fail++; $display("FAIL oor_fetch: got f_done %b f_err %b d_done %b en %b, expected 1 1 0 0",
                               f_done_a, f_err_a, d_done_a, mem_en_a); end
        f_req = 1'b0;
        tick();
        n_checks++; if (en_cnt_a != en0 || ram_a_rd(10'd0) !== 64'h1000) begin
            n_fail++; $display("FAIL oor_no_ram: got strobes %0d word0 %h, expected 0 1000", en_cnt_a - en0, ram_a_rd(10'd0)); end
    endtask

    task automatic test_contention();
        int last_cyc;
        int k;
        logic [9:0] exp_addr;
        last_cyc = 0;
        f_addr = 64'd10; d_addr = 64'd20; d_we = 1'b0; f_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            k = 0;
            do begin tick(); k++; end while (mem_en_a !== 1'b1 && k < 20);
            exp_addr = (i == 4 || i == 9) ? 10'd10 : 10'd20;
            n_checks++; if (mem_en_a !== 1'b1 || mem_addr_a !== exp_addr) begin
                n_fail++; $display("FAIL cont_grant%0d: got en %b addr %0d, expected 1 %0d", i, mem_en_a, mem_addr_a, exp_addr); end
            if (i > 0) begin
                n_checks++; if (cyc - last_cyc != 4) begin
                    n_fail++; $display("FAIL cont_spacing%0d: got %0d cycles, expected 4", i, cyc - last_cyc); end
            end
            last_cyc = cyc;
        end
        f_req = 1'b0; d_req = 1'b0;
        tick();
        tick();
        n_checks++; if (f_done_a !== 1'b1 || d_done_a !== 1'b0 || f_rdata_a !== 64'h100A || d_rdata_a !== 64'h1014) begin
            n_fail++; $display("FAIL cont_final: got f_done %b d_done %b f_rdata %h d_rdata %h, expected 1 0 100a 1014",
                               f_done_a, d_done_a, f_rdata_a, d_rdata_a); end
        tick();
    endtask

    task automatic test_fetch_we();
        int we0;
        we0 = we_cnt_a;
        d_req = 1'b0; d_we = 1'b1; d_wdata = 64'hFFFF; f_req = 1'b1; f_addr = 64'd5;
        tick();
        n_checks++; if (mem_en_a !== 1'b1 || mem_we_a !== 1'b0 || mem_addr_a !== 10'd5) begin
            n_fail++; $display("FAIL fwe_access: got en %b we %b addr %0d, expected 1 0 5", mem_en_a, mem_we_a, mem_addr_a); end
        tick();
        tick();
        n_checks++; if (f_done_a !== 1'b1 || f_err_a !== 1'b0 || f_rdata_a !== 64'hDEAD_BEEF || d_done_a !== 1'b0) begin
            n_fail++; $display("FAIL fwe_done: got done %b err %b rdata %h d_done %b, expected 1 0 deadbeef 0",
                               f_done_a, f_err_a, f_rdata_a, d_done_a); end
        f_req = 1'b0; d_we = 1'b0;
        tick();
        n_checks++; if (we_cnt_a != we0 || d_rdata_a !== 64'h1014) begin
            n_fail++; $display("FAIL fwe_side: got we cycles %0d d_rdata %h, expected 0 1014", we_cnt_a - we0, d_rdata_a); end
    endtask

    task automatic test_reset_mid_access();
        int dn0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'd7; d_wdata = 64'h7777;
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++; if ({mem_en_a, mem_we_a, f_done_a, d_done_a, f_err_a, d_err_a} !== 6'd0 ||
                        mem_addr_a !== 10'd0 || mem_wdata_a !== 64'd0 || f_rdata_a !== 64'd0 || d_rdata_a !== 64'd0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got ctrl %b addr %0d wdata %h rdata %h/%h, expected all 0",
                               {mem_en_a, mem_we_a, f_done_a, d_done_a, f_err_a, d_err_a}, mem_addr_a, mem_wdata_a, f_rdata_a, d_rdata_a); end
        d_req = 1'b0; d_we = 1'b0;
        rst_n = 1'b1;
        dn0 = done_cnt_a;
        repeat (5) tick();
        n_checks++; if (done_cnt_a != dn0 || mem_en_a !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_no_done: got %0d done pulses en %b, expected 0 0", done_cnt_a - dn0, mem_en_a); end
        d_req = 1'b1; d_addr = 64'd3;
        tick();
        n_checks++; if (mem_en_a !== 1'b1 || mem_addr_a !== 10'd3) begin
            n_fail++; $display("FAIL rst_fresh_access: got en %b addr %0d, expected 1 3", mem_en_a, mem_addr_a); end
        tick();
        tick();
        n_checks++; if (d_done_a !== 1'b1 || d_rdata_a !== 64'h1003) begin
            n_fail++; $display("FAIL rst_fresh_done: got done %b rdata %h, expected 1 1003", d_done_a, d_rdata_a); end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_read_lat3();
        d_req_b = 1'b1; d_we_b = 1'b0; d_addr_b = 64'd1023;
        tick();
        n_checks++; if (mem_en_b !== 1'b1 || mem_we_b !== 1'b0 || mem_addr_b !== 10'd1023 || mem_wdata_b !== 64'd0) begin
            n_fail++; $display("FAIL lat3_access: got en %b we %b addr %0d wdata %h, expected 1 0 1023 0",
                               mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            n_checks++; if (d_done_b !== 1'b0 || mem_en_b !== 1'b0) begin
                n_fail++; $display("FAIL lat3_wait_n%0d: got done %b en %b, expected 0 0", c, d_done_b, mem_en_b); end
        end
        tick();
        n_checks++; if (d_done_b !== 1'b1 || d_err_b !== 1'b0 || d_rdata_b !== 64'h13FF || f_done_b !== 1'b0 || f_err_b !== 1'b0) begin
            n_fail++; $display("FAIL lat3_done: got done %b err %b rdata %h f_done %b f_err %b, expected 1 0 13ff 0 0",
                               d_done_b, d_err_b, d_rdata_b, f_done_b, f_err_b); end
        d_req_b = 1'b0;
        tick();
        d_req_b = 1'b1; d_addr_b = 64'd1024;
        tick();
        n_checks++; if (d_done_b !== 1'b1 || d_err_b !== 1'b1 || mem_en_b !== 1'b0 || f_rdata_b !== 64'd0) begin
            n_fail++; $display("FAIL lat3_oor: got done %b err %b en %b f_rdata %h, expected 1 1 0 0",
                               d_done_b, d_err_b, mem_en_b, f_rdata_b); end
        d_req_b = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read_after_write();
        test_out_of_range();
        test_contention();
        test_fetch_we();
        test_reset_mid_access();
        test_read_lat3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 1024 x 64-bit data RAM between two requesters: the instruction-fetch port (read-only) and the memory-stage data port (read/write).
- Sequences every access through a grant/access/response FSM.
- Range-checks the address; out-of-range accesses are answered with an error and never reach the RAM.
- Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
- MEM_DEPTH, 1024, number of 64-bit RAM words; valid addresses are 0..MEM_DEPTH-1.
- MEM_AW, 10, RAM address width (log2 MEM_DEPTH).
- READ_LAT, 1, cycles from mem_en high to mem_rdata valid (1..4).
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- f_req  in  1  fetch request; held high until f_done
- f_addr  in  64  fetch word address
- f_rdata  out  64  fetch read data; valid while f_done=1
- f_done  out  1  one-cycle completion pulse, fetch
- f_err  out  1  address out of range; valid with f_done
- d_req  in  1  data request; held high until d_done
- d_we  in  1  1=write (rmmovq/call/pushq), 0=read (mrmovq/ret/popq)
- d_addr  in  64  data word address
- d_wdata  in  64  write data
- d_rdata  out  64  data read data; valid while d_done=1
- d_done  out  1  one-cycle completion pulse, data
- d_err  out  1  address out of range; valid with d_done
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable (only with mem_en)
- mem_addr  out  MEM_AW  RAM address
- mem_wdata  out  64  RAM write data
- mem_rdata  in  64  RAM read data

Behaviour:
- Reset (rst_n=0 at rising edge):
  - State goes to IDLE; starvation count goes to 0.
  - All outputs go to 0: mem_en, mem_we, mem_addr, mem_wdata, f/d_done, f/d_err, f/d_rdata.
  - Reset mid-transaction abandons it: no done pulse and no late mem_en; a write not yet strobed is dropped.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: samples requests and decides the grant.
  - Only d_req: grant data.
  - Only f_req: grant fetch.
  - Both: grant data unless starvation count = STARVE_MAX, in which case grant fetch.
  - Counter: increments on a data grant while f_req is high; clears on any fetch grant; holds otherwise.
  - At grant, latch owner, addr, we (fetch forces we=0) and wdata.
  - Addr >= MEM_DEPTH: go to RESP with err=1; mem_en stays 0.
  - Addr in range: go to ACCESS.
- ACCESS (1 cycle): mem_en=1, mem_we=latched we, mem_addr=latched addr[MEM_AW-1:0], mem_wdata=latched wdata. Go to WAIT.
  - mem_en is 0 in every other state.
  - mem_we is never 1 when mem_en=0.
- WAIT: count READ_LAT cycles (writes wait identically, for uniform timing). In the last WAIT cycle register mem_rdata into the owner's rdata (reads only). Go to RESP.
- RESP (1 cycle): owner's done=1; err as determined at grant. Return to IDLE.
  - Requests are ignored in RESP.
  - Non-owner done/err stay 0.
  - rdata holds its value until the next read completes for that port.
- Latency:
  - Grant sampled in IDLE at cycle N; mem_en high in cycle N+1; done in cycle N+2+READ_LAT (N+3 at default).
  - Error response: done+err in cycle N+1.
  - Minimum spacing between grants: READ_LAT+3 cycles.
- Requester rules:
  - Dropping req after grant does not cancel the access; done still pulses.
  - req still high in the IDLE after done is a new request.
  - d_we, d_addr, d_wdata changes after grant are ignored (already latched).
- Address arithmetic: full 64-bit unsigned compare against MEM_DEPTH. The in-range test is addr < MEM_DEPTH only; no negative/sign interpretation.
- Simultaneous events: both requests rising in the same IDLE cycle resolve per the priority rule above; a fetch request arriving during a data access waits in IDLE priority evaluation.

Test Plan:
- Read after write: d_req, d_we=1, d_addr=5, d_wdata=0xDEAD_BEEF; then d_req, d_we=0, d_addr=5 -> mem_en 1 cycle after grant; d_done at N+3; d_rdata=0xDEAD_BEEF; d_err=0.
- Out of range: d_addr=1024 write, then f_addr=0xFFFF_FFFF_FFFF_FFF8 -> each done+err=1 at N+1; mem_en never asserted; RAM word 0 unchanged.
- Contention: f_req and d_req held continuously, STARVE_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F; mem_en spacing 4 cycles.
- Fetch-only write attempt: f_req with d_we=1 and d_req=0 -> mem_we=0 throughout; f_rdata=RAM[f_addr].
- Reset mid-access: assert rst_n=0 in the cycle ACCESS is entered for a write to addr 7 -> all outputs 0 next cycle; no done; after release, a fresh request completes normally.
- READ_LAT=3 build: read addr 1023 -> mem_en at N+1; d_done at N+5; rdata=RAM[1023]; d_err=0.
